// File: rtl/fetch_unit_pkg.sv
// Shared state encoding and default parameters for the instruction fetch stage.
package fetch_unit_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam int          DEF_WIDTH    = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0;
  localparam int          DEF_TIMEOUT  = 255;
  localparam int          TO_W         = 8;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: load has priority over increment, otherwise hold.
module pc_counter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld)       pc_d = d;
    else if (inc) pc_d = pc_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VAL;
    else     pc_q <= pc_d;
  end

  assign q = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests words over req/ack, pulses ir_ld per word,
// then advances the PC by one or to a pending/immediate jump target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int               TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] ir_d,
  output logic             ir_ld,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             fault
);
  state_e           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             fault_q, fault_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] ir_q, ir_nxt;
  logic             pc_ld, pc_inc;
  logic [WIDTH-1:0] pc_nxt;

  assign cnt_inc = cnt_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    ir_nxt  = ir_q;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_nxt  = jmp_addr;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pc_ld = jmp;
        if (run) begin
          state_d = FETCH;
          fault_d = 1'b0;
        end
      end
      FETCH: begin
        // The in-flight word still issues; the jump lands at the next ISSUE.
        if (jmp) begin
          pend_d = 1'b1;
          tgt_d  = jmp_addr;
        end
        if (mem_ack) begin
          ir_nxt  = mem_rdata;
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (cnt_inc == TO_W'(TIMEOUT)) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ISSUE: begin
        pend_d = 1'b0;
        if (jmp) begin
          pc_ld = 1'b1;
        end else if (pend_q) begin
          pc_ld  = 1'b1;
          pc_nxt = tgt_q;
        end else begin
          pc_inc = 1'b1;
        end
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      ir_q    <= ir_nxt;
    end
  end

  pc_counter #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .ld  (pc_ld),
    .d   (pc_nxt),
    .inc (pc_inc),
    .q   (pc)
  );

  assign mem_req  = (state_q == FETCH);
  assign ir_ld    = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign mem_addr = pc;
  assign ir_d     = ir_q;
  assign fault    = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, delayed ack, jump, wrap, timeout, reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, run, jmp;
  logic [15:0] jmp_addr;
  logic        mem_req, mem_ack, ir_ld, busy, fault;
  logic [15:0] mem_addr, mem_rdata, ir_d, pc;
  logic        mem_req2, ir_ld2, busy2, fault2;
  logic [15:0] mem_addr2, ir_d2, pc2;

  int n_chk = 0;
  int n_err = 0;

  // Memory model: acks once the request has waited ack_delay cycles.
  logic       ack_en;
  int         ack_delay;
  int         wait_cnt;

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && ack_en && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_addr + 16'h1000;

  always @(posedge clk or posedge rst) begin
    if (rst)                     wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .run(run), .jmp(jmp), .jmp_addr(jmp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_d(ir_d), .ir_ld(ir_ld), .pc(pc), .busy(busy), .fault(fault)
  );

  // Wrap instance: always-acking memory, reset PC at the top of the space.
  fetch_unit #(.WIDTH(16), .RESET_PC(16'hFFFF), .TIMEOUT(8)) dut_wrap (
    .clk(clk), .rst(rst), .run(run), .jmp(jmp), .jmp_addr(jmp_addr),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_req2),
    .mem_rdata(mem_addr2 + 16'h1000),
    .ir_d(ir_d2), .ir_ld(ir_ld2), .pc(pc2), .busy(busy2), .fault(fault2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; jmp = 1'b0; jmp_addr = '0;
    ack_en = 1'b1; ack_delay = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, 16'h0);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_ld", ir_ld, 0);
    chk("rst_ird", ir_d, 16'h0);
    chk("rst_fault", fault, 0);
    chk("rst_pc_wrap", pc2, 16'hFFFF);

    // 1: zero-wait streaming
    run = 1'b1;
    step();  // e1
    chk("t1_req", mem_req, 1);
    chk("t1_addr0", mem_addr, 16'h0);
    chk("t1_ld0", ir_ld, 0);
    step();  // e2
    chk("t1_ld1", ir_ld, 1);
    chk("t1_ir0", ir_d, 16'h1000);
    chk("t1_pc0", pc, 16'h0);
    chk("t4_ir", ir_d2, 16'h0FFF);
    step();  // e3
    chk("t1_pc1", pc, 16'h1);
    chk("t1_ldlow", ir_ld, 0);
    chk("t4_wrap", pc2, 16'h0000);
    step();  // e4
    chk("t1_ir1", ir_d, 16'h1001);
    step();  // e5
    chk("t1_pc2", pc, 16'h2);
    step();  // e6
    chk("t1_ld3", ir_ld, 1);
    chk("t1_ir2", ir_d, 16'h1002);
    step();  // e7
    chk("t1_pc3", pc, 16'h3);

    // 2: ack delayed 3 cycles
    ack_delay = 3;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", mem_req, 1);
      chk("t2_addr", mem_addr, 16'h3);
      chk("t2_noload", ir_ld, 0);
      step();  // e8..e11
    end
    chk("t2_ld", ir_ld, 1);
    chk("t2_ir", ir_d, 16'h1003);
    ack_delay = 0;
    step();  // e12 FETCH pc4
    chk("t2_pc4", pc, 16'h4);
    step();  // e13 ISSUE
    ack_delay = 2;

    // 3: jump during fetch of address 5
    step();  // e14 FETCH pc5
    chk("t3_addr5", mem_addr, 16'h5);
    jmp = 1'b1; jmp_addr = 16'h0040;
    step();  // e15
    jmp = 1'b0; jmp_addr = 16'h0;
    chk("t3_hold", mem_addr, 16'h5);
    step();  // e16
    step();  // e17 ISSUE
    chk("t3_ld", ir_ld, 1);
    chk("t3_ir", ir_d, 16'h1005);
    step();  // e18
    chk("t3_jaddr", mem_addr, 16'h0040);
    chk("t3_jreq", mem_req, 1);

    // 5: timeout with run dropped mid-request
    ack_en = 1'b0; run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();  // e19..e25
      chk("t5_held", mem_req, 1);
    end
    chk("t5_nofault", fault, 0);
    step();  // e26
    chk("t5_fault", fault, 1);
    chk("t5_busy", busy, 0);
    chk("t5_pc", pc, 16'h0040);
    step();  // e27
    chk("t5_sticky", fault, 1);
    run = 1'b1;
    step();  // e28
    chk("t5_clear", fault, 0);
    chk("t5_refetch", busy, 1);

    // 6a: drop run while fetching
    ack_en = 1'b1; ack_delay = 0; run = 1'b0;
    step();  // e29
    chk("t6_ld", ir_ld, 1);
    chk("t6_ir", ir_d, 16'h1040);
    step();  // e30
    chk("t6_idle", busy, 0);
    chk("t6_pc", pc, 16'h0041);

    // IDLE jump, then jump together with run
    jmp = 1'b1; jmp_addr = 16'h1234;
    step();
    chk("idle_jmp_pc", pc, 16'h1234);
    chk("idle_jmp_busy", busy, 0);
    jmp_addr = 16'h0200; run = 1'b1; ack_en = 1'b0;
    step();
    jmp = 1'b0;
    chk("runjmp_addr", mem_addr, 16'h0200);
    chk("runjmp_req", mem_req, 1);

    // 6b: async reset between edges mid-FETCH
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_ld", ir_ld, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pc", pc, 16'h0);
    #1;
    rst = 1'b0; run = 1'b0;
    step();
    chk("t6_post", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
